pmem_bus_master: RTL and testbench

PMEM_BUS_MASTER -- requirements
Module: pmem_bus_master

---
 rtl/pmem_bus_master.sv | 133 +++++++++++++
 tb/tb_pmem_bus_master.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/pmem_bus_master.sv
// pmem_bus_master: command/response master for a select/ready peripheral bus; define PMEM_BUS_MASTER_TIMEOUT_EN to add the TIMEOUT wait abort.
module pmem_bus_master #(
  parameter int TIMEOUT = 16
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic       cmd_write,
  input  logic [7:0] cmd_addr,
  input  logic [7:0] cmd_wdata,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic [7:0] rsp_rdata,
  output logic       rsp_err,
  output logic       pm_select,
  output logic [7:0] pm_addr,
  output logic [7:0] pm_data_out,
  output logic       pm_write,
  input  logic [7:0] pm_data_in,
  input  logic       pm_data_ready
);
  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
  state_t state_q, state_d;
  logic cmd_ready_q, cmd_ready_d, rsp_valid_q, rsp_valid_d;
  logic pm_select_q, pm_select_d, pm_write_q, pm_write_d;
  logic [7:0] rsp_rdata_q, rsp_rdata_d, pm_addr_q, pm_addr_d, pm_data_out_q, pm_data_out_d;
  logic timeout_hit;

  if (TIMEOUT < 2 || TIMEOUT > 255) begin : g_bad_timeout
    $error("pmem_bus_master: TIMEOUT must be within 2..255");
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= IDLE;
      cmd_ready_q   <= 1'b0;
      rsp_valid_q   <= 1'b0;
      rsp_rdata_q   <= '0;
      pm_select_q   <= 1'b0;
      pm_write_q    <= 1'b0;
      pm_addr_q     <= '0;
      pm_data_out_q <= '0;
    end else begin
      state_q       <= state_d;
      cmd_ready_q   <= cmd_ready_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_rdata_q   <= rsp_rdata_d;
      pm_select_q   <= pm_select_d;
      pm_write_q    <= pm_write_d;
      pm_addr_q     <= pm_addr_d;
      pm_data_out_q <= pm_data_out_d;
    end
  end

  // Every output is a flop so reset forces all of them low with no clock.
  always_comb begin
    state_d       = state_q;
    cmd_ready_d   = cmd_ready_q;
    rsp_valid_d   = rsp_valid_q;
    rsp_rdata_d   = rsp_rdata_q;
    pm_select_d   = pm_select_q;
    pm_write_d    = pm_write_q;
    pm_addr_d     = pm_addr_q;
    pm_data_out_d = pm_data_out_q;
    case (state_q)
      IDLE: begin
        cmd_ready_d = 1'b1;
        if (cmd_valid && cmd_ready_q) begin
          state_d       = ACCESS;
          cmd_ready_d   = 1'b0;
          pm_select_d   = 1'b1;
          pm_write_d    = cmd_write;
          pm_addr_d     = cmd_addr;
          pm_data_out_d = cmd_wdata;
        end
      end
      ACCESS: begin
        if (pm_data_ready || timeout_hit) begin
          state_d       = RESP;
          rsp_valid_d   = 1'b1;
          rsp_rdata_d   = (pm_data_ready && !pm_write_q) ? pm_data_in : 8'd0;
          pm_select_d   = 1'b0;
          pm_write_d    = 1'b0;
          pm_addr_d     = '0;
          pm_data_out_d = '0;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          state_d     = IDLE;
          cmd_ready_d = 1'b1;
          rsp_valid_d = 1'b0;
          rsp_rdata_d = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

`ifdef PMEM_BUS_MASTER_TIMEOUT_EN
  logic [7:0] cnt_q, cnt_d;
  logic err_q, err_d;
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end
  assign timeout_hit = (state_q == ACCESS) && (cnt_q == 8'(TIMEOUT - 1));
  // A ready arriving on the expiry edge wins, so the error needs !pm_data_ready.
  always_comb begin
    cnt_d = (state_q == ACCESS && !pm_data_ready) ? cnt_q + 8'd1 : 8'd0;
    err_d = (state_q == ACCESS) ? (timeout_hit && !pm_data_ready)
                                : (state_q == RESP && !rsp_ready && err_q);
  end
  assign rsp_err = err_q;
`else
  assign timeout_hit = 1'b0;
  assign rsp_err     = 1'b0;
`endif

  assign cmd_ready   = cmd_ready_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_rdata   = rsp_rdata_q;
  assign pm_select   = pm_select_q;
  assign pm_write    = pm_write_q;
  assign pm_addr     = pm_addr_q;
  assign pm_data_out = pm_data_out_q;
endmodule

// File: tb/tb_pmem_bus_master.sv
// tb_pmem_bus_master: randomized transactions against a delay-programmable responder and a cycle-count model of the master.
module tb_pmem_bus_master;
  localparam int TIMEOUT = 16;
`ifdef PMEM_BUS_MASTER_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif
  logic clock = 1'b0, reset_n = 1'b0;
  logic cmd_valid = 1'b0, cmd_ready, cmd_write = 1'b0;
  logic [7:0] cmd_addr = '0, cmd_wdata = '0;
  logic rsp_valid, rsp_ready = 1'b0, rsp_err;
  logic [7:0] rsp_rdata;
  logic pm_select, pm_write, pm_data_ready = 1'b0;
  logic [7:0] pm_addr, pm_data_out, pm_data_in = '0;
  int tests = 0, fails = 0;
  int resp_delay = 1, sel_cnt = 0, low_run = 100;
  logic [7:0] resp_data = '0;
  logic prev_sel = 1'b0;

  pmem_bus_master #(.TIMEOUT(TIMEOUT)) dut (
    .clock(clock), .reset_n(reset_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .pm_select(pm_select), .pm_addr(pm_addr), .pm_data_out(pm_data_out), .pm_write(pm_write),
    .pm_data_in(pm_data_in), .pm_data_ready(pm_data_ready)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Responder raises ready once it has seen select for resp_delay+1 cycles; junk elsewhere.
  always @(negedge clock) begin
    if (pm_select) begin
      sel_cnt++;
      pm_data_ready = (sel_cnt > resp_delay);
      pm_data_in    = resp_data;
    end else begin
      sel_cnt       = 0;
      pm_data_ready = 1'($urandom_range(0, 1));
      pm_data_in    = 8'($urandom);
    end
  end

  always @(negedge clock) begin
    if (reset_n) begin
      if (!pm_select) check("bus_idle_zero", {15'd0, pm_write, pm_addr, pm_data_out}, 32'd0);
      if (pm_select && !prev_sel) check("select_gap_ge2", 32'(low_run >= 2), 32'd1);
      low_run = pm_select ? 0 : low_run + 1;
    end
    prev_sel = pm_select;
  end

  task automatic run_txn(input bit wr, input logic [7:0] addr, input logic [7:0] wd,
                         input logic [7:0] rd, input int dly, input int stall, input bit hold);
    int cyc, exp_hi;
    bit exp_err;
    logic [7:0] exp_rd;
    exp_err    = TO_EN && (dly + 1 > TIMEOUT);
    exp_hi     = exp_err ? TIMEOUT : dly + 1;
    exp_rd     = (wr || exp_err) ? 8'd0 : rd;
    resp_delay = dly;
    resp_data  = rd;
    cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr; cmd_wdata = wd;
    cyc = 0;
    while (!cmd_ready && cyc < 50) begin @(negedge clock); cyc++; end
    check("accept", 32'(cmd_ready), 32'd1);
    @(negedge clock);
    if (!hold) begin
      cmd_valid = 1'b0; cmd_write = 1'($urandom); cmd_addr = 8'($urandom); cmd_wdata = 8'($urandom);
    end
    cyc = 0;
    while (!rsp_valid && cyc < 300) begin
      check("select_high", 32'(pm_select), 32'd1);
      check("cmd_ready_busy", 32'(cmd_ready), 32'd0);
      check("pm_fields", {15'd0, pm_write, pm_addr, pm_data_out}, {15'd0, wr, addr, wd});
      @(negedge clock);
      cyc++;
    end
    check("rsp_valid", 32'(rsp_valid), 32'd1);
    check("select_cycles", 32'(cyc), 32'(exp_hi));
    check("rsp_rdata", 32'(rsp_rdata), 32'(exp_rd));
    check("rsp_err", 32'(rsp_err), 32'(exp_err));
    check("select_low_resp", 32'(pm_select), 32'd0);
    repeat (stall) begin
      @(negedge clock);
      check("stall_valid", 32'(rsp_valid), 32'd1);
      check("stall_data", {23'd0, rsp_err, rsp_rdata}, {23'd0, exp_err, exp_rd});
      check("stall_cmd_ready", 32'(cmd_ready), 32'd0);
    end
    rsp_ready = 1'b1;
    @(negedge clock);
    rsp_ready = 1'b0;
    check("rsp_done", 32'(rsp_valid), 32'd0);
  endtask

  task automatic reset_mid_access(input int wait_n);
    resp_delay = 1000;
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 8'h55; cmd_wdata = 8'h00;
    while (!cmd_ready) @(negedge clock);
    @(negedge clock);
    cmd_valid = 1'b0;
    repeat (wait_n - 1) @(negedge clock);
    check("sel_held_before_reset", 32'(pm_select), 32'd1);
    #2 reset_n = 1'b0;
    #1;
    check("async_rst_select", 32'(pm_select), 32'd0);
    check("async_rst_outs", {cmd_ready, rsp_valid, rsp_err, pm_write, rsp_rdata, pm_addr, pm_data_out},
          32'd0);
    @(negedge clock);
    reset_n = 1'b1;
    #1 check("cmd_ready_before_edge", 32'(cmd_ready), 32'd0);
    @(posedge clock);
    #1 check("cmd_ready_first_edge", 32'(cmd_ready), 32'd1);
    repeat (6) begin
      @(negedge clock);
      check("no_rsp_after_abort", {30'd0, rsp_valid, pm_select}, 32'd0);
    end
  endtask

  initial begin
    repeat (3) @(negedge clock);
    check("reset_outs", {cmd_ready, rsp_valid, rsp_err, pm_write, rsp_rdata, pm_addr, pm_data_out}, 32'd0);
    check("reset_select", 32'(pm_select), 32'd0);
    reset_n = 1'b1;
    #1 check("release_cmd_ready", 32'(cmd_ready), 32'd0);
    @(posedge clock);
    #1 check("first_edge_cmd_ready", 32'(cmd_ready), 32'd1);
    @(negedge clock);
    run_txn(1'b1, 8'h38, 8'hA5, 8'h00, 1, 0, 1'b0);
    run_txn(1'b0, 8'h36, 8'h00, 8'h5C, 1, 0, 1'b0);
    run_txn(1'b1, 8'h36, 8'h11, 8'h00, 1, 5, 1'b1);
    run_txn(1'b1, 8'h36, 8'h22, 8'h00, 1, 0, 1'b0);
    run_txn(1'b0, 8'h10, 8'h00, 8'hC3, 0, 1, 1'b0);
    run_txn(1'b0, 8'h11, 8'h00, 8'h3C, TIMEOUT - 2, 0, 1'b0);
    run_txn(1'b0, 8'h12, 8'h00, 8'h96, TIMEOUT - 1, 0, 1'b0);
    run_txn(1'b0, 8'h13, 8'h00, 8'h69, TIMEOUT, 0, 1'b0);
    for (int i = 0; i < 30; i++)
      run_txn(1'($urandom), 8'($urandom), 8'($urandom), 8'($urandom),
              int'($urandom_range(0, 5)), int'($urandom_range(0, 3)), 1'b0);
`ifdef PMEM_BUS_MASTER_TIMEOUT_EN
    run_txn(1'b0, 8'h44, 8'h00, 8'hEE, 1000, 2, 1'b0);
    reset_mid_access(2);
`else
    reset_mid_access(100);
`endif
    run_txn(1'b1, 8'h7F, 8'h5A, 8'h00, 2, 1, 1'b0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
